// File: rtl/formula_2_distributor_pkg.sv
// Shared sizing defaults and pointer helpers
// for the formula_2 distributor slice.
package formula_dist_pkg;

  localparam int N_WORKERS_DEF = 4;
  localparam int W_DEF         = 32;

  // Pointer width; a single worker still needs one bit.
  function automatic int ptr_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Round-robin step that wraps at n-1, so n need
  // not be a power of two.
  function automatic int next_ptr(
    input int p,
    input int n
  );
    return (p >= n - 1) ? 0 : p + 1;
  endfunction

endpackage

// File: rtl/formula_2_distributor_if.sv
// Upstream argument/result handshake plus the
// fan-out bus towards the formula workers.
interface formula_2_distributor_if
  import formula_dist_pkg::*;
#(
  parameter int N_WORKERS = N_WORKERS_DEF,
  parameter int W         = W_DEF
);

  logic                   arg_vld;
  logic [W-1:0]           a;
  logic [W-1:0]           b;
  logic [W-1:0]           c;
  logic                   arg_rdy;
  logic                   res_vld;
  logic [W-1:0]           res;
  logic [N_WORKERS-1:0]   w_arg_vld;
  logic [W-1:0]           w_a;
  logic [W-1:0]           w_b;
  logic [W-1:0]           w_c;
  logic [N_WORKERS-1:0]   w_res_vld;
  logic [N_WORKERS*W-1:0] w_res;
  logic                   err;

  // Distributor side.
  modport slave (
    input  arg_vld, a, b, c,
    input  w_res_vld, w_res,
    output arg_rdy, res_vld, res,
    output w_arg_vld, w_a, w_b, w_c,
    output err
  );

  // Environment side: upstream plus workers.
  modport master (
    output arg_vld, a, b, c,
    output w_res_vld, w_res,
    input  arg_rdy, res_vld, res,
    input  w_arg_vld, w_a, w_b, w_c,
    input  err
  );

endinterface

// File: rtl/formula_2_distributor.sv
// Round-robin dispatch to N formula workers with
// in-order re-emission of out-of-order results.
module formula_2_distributor
  import formula_dist_pkg::*;
#(
  parameter int N_WORKERS = N_WORKERS_DEF,
  parameter int W         = W_DEF
) (
  input logic              clk,
  input logic              rst,
  formula_2_distributor_if.slave bus
);

  localparam int PW = ptr_w(N_WORKERS);
  typedef logic [PW-1:0] ptr_t;

  ptr_t                 wr_ptr;
  ptr_t                 rd_ptr;
  logic [N_WORKERS-1:0] busy;
  logic [N_WORKERS-1:0] done;
  logic [W-1:0]         slot [N_WORKERS];
  logic [W-1:0]         wres [N_WORKERS];
  logic [N_WORKERS-1:0] hit;
  logic [N_WORKERS-1:0] stray;
  logic [N_WORKERS-1:0] sel;
  logic                 rdy;
  logic                 accept;
  logic                 fast;
  logic                 emit;
  logic [W-1:0]         emit_data;
  logic                 res_vld_q;
  logic [W-1:0]         res_q;
  logic                 err_q;

  // A strobe only counts if its worker holds an
  // accepted argument; otherwise it is a fault.
  for (genvar i = 0; i < N_WORKERS; i++) begin : g_w
    assign wres[i]  = bus.w_res[i*W +: W];
    assign hit[i]   = bus.w_res_vld[i] & busy[i];
    assign stray[i] = bus.w_res_vld[i] & ~busy[i];
  end

  assign rdy    = ~busy[wr_ptr];
  assign accept = bus.arg_vld & rdy;

  assign bus.arg_rdy = rdy;
  assign bus.w_a     = bus.a;
  assign bus.w_b     = bus.b;
  assign bus.w_c     = bus.c;
  assign bus.res_vld = res_vld_q;
  assign bus.res     = res_q;
  assign bus.err     = err_q;

  // One-hot dispatch strobe towards wr_ptr's worker.
  always_comb begin
    sel = '0;
    if (accept) begin
      sel[wr_ptr] = 1'b1;
    end
  end

  assign bus.w_arg_vld = sel;

  // Oldest result: bypass a live strobe, else the
  // buffered slot.
  always_comb begin
    fast      = hit[rd_ptr];
    emit      = fast | done[rd_ptr];
    emit_data = fast ? wres[rd_ptr] : slot[rd_ptr];
  end

  // Pointers, occupancy, result register, error flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      busy      <= '0;
      done      <= '0;
      res_vld_q <= 1'b0;
      res_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      if (accept) begin
        busy[wr_ptr] <= 1'b1;
        wr_ptr <= ptr_t'(next_ptr(int'(wr_ptr), N_WORKERS));
      end
      for (int i = 0; i < N_WORKERS; i++) begin
        if (hit[i]) begin
          done[i] <= 1'b1;
        end
      end
      if (|stray) begin
        err_q <= 1'b1;
      end
      res_vld_q <= emit;
      // Emission overrides the buffered flag set
      // above, so the bypassed result is not kept.
      if (emit) begin
        res_q        <= emit_data;
        busy[rd_ptr] <= 1'b0;
        done[rd_ptr] <= 1'b0;
        rd_ptr <= ptr_t'(next_ptr(int'(rd_ptr), N_WORKERS));
      end
    end
  end

  // Result buffer; data only, flags qualify it.
  always_ff @(posedge clk) begin
    for (int i = 0; i < N_WORKERS; i++) begin
      if (hit[i]) begin
        slot[i] <= wres[i];
      end
    end
  end

endmodule

// File: tb/tb_formula_2_distributor.sv
// Randomized bench for formula_2_distributor with
// latency-programmable stub workers and a job model.
module tb_formula_2_distributor;

  import formula_dist_pkg::*;

  localparam int N = 4;
  localparam int W = 32;
  localparam int MAXJ = 256;

  logic clk = 1'b0;
  logic rst;

  formula_2_distributor_if #(.N_WORKERS(N), .W(W)) bus ();

  formula_2_distributor #(
    .N_WORKERS(N),
    .W(W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] c;
  } trip_t;

  int n_checks;
  int n_fail;
  int cyc;
  int na;
  int ne;
  int spur;
  logic [W-1:0] exp_val [MAXJ];
  int stb_cyc [MAXJ];
  logic [W-1:0] last_res;
  logic err_exp;
  trip_t pend [$];
  int lat [N];
  bit w_act [N];
  int w_cnt [N];
  int w_job [N];
  logic [W-1:0] w_val [N];

  function automatic longint isq(input longint x);
    longint r = 0;
    longint t;
    for (int k = 20; k >= 0; k--) begin
      t = r | (longint'(1) << k);
      if (t * t <= x) r = t;
    end
    return r;
  endfunction

  function automatic logic [W-1:0] formula(
    input logic [W-1:0] a,
    input logic [W-1:0] b,
    input logic [W-1:0] c
  );
    longint ia, ib, ic;
    ia = longint'({32'd0, a});
    ib = longint'({32'd0, b});
    ic = longint'({32'd0, c});
    return W'(isq(ia + isq(ib + isq(ic))));
  endfunction

  function automatic logic [W-1:0] rnd();
    return $urandom & 32'h7fff_ffff;
  endfunction

  task automatic clear_model();
    na = 0;
    ne = 0;
    spur = -1;
    pend.delete();
    last_res = '0;
    err_exp = 1'b0;
    for (int i = 0; i < N; i++) w_act[i] = 1'b0;
  endtask

  task automatic push(
    input logic [W-1:0] a,
    input logic [W-1:0] b,
    input logic [W-1:0] c
  );
    trip_t t;
    t.a = a;
    t.b = b;
    t.c = c;
    pend.push_back(t);
  endtask

  task automatic set_lat(input int l0, input int l1,
                         input int l2, input int l3);
    lat[0] = l0;
    lat[1] = l1;
    lat[2] = l2;
    lat[3] = l3;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.arg_vld = 1'b0;
    bus.a = '0;
    bus.b = '0;
    bus.c = '0;
    bus.w_res_vld = '0;
    bus.w_res = '0;
    @(posedge clk);
    @(negedge clk);
    clear_model();
    rst = 1'b0;
  endtask

  // One clock cycle, entered and left at a negedge.
  task automatic tick();
    logic exp_vld;
    logic exp_rdy;
    logic [N-1:0] exp_sel;
    logic [W-1:0] da, db, dc;
    logic dv;
    int w;
    exp_vld = (ne < na) && (stb_cyc[ne] >= 0)
              && (stb_cyc[ne] < cyc);
    n_checks++;
    if (bus.res_vld !== exp_vld) begin
      n_fail++;
      $display("FAIL res_vld cyc %0d: got %b want %b",
               cyc, bus.res_vld, exp_vld);
    end
    if (exp_vld) begin
      last_res = exp_val[ne];
      ne++;
    end
    n_checks++;
    if (bus.res !== last_res) begin
      n_fail++;
      $display("FAIL res cyc %0d: got %0h want %0h",
               cyc, bus.res, last_res);
    end
    n_checks++;
    if (bus.err !== err_exp) begin
      n_fail++;
      $display("FAIL err cyc %0d: got %b want %b",
               cyc, bus.err, err_exp);
    end
    bus.w_res_vld = '0;
    for (int i = 0; i < N; i++) begin
      bus.w_res[i*W +: W] = $urandom;
      if (w_act[i]) begin
        if (w_cnt[i] == 1) begin
          bus.w_res_vld[i] = 1'b1;
          bus.w_res[i*W +: W] = w_val[i];
          stb_cyc[w_job[i]] = cyc;
          w_act[i] = 1'b0;
        end else begin
          w_cnt[i]--;
        end
      end
    end
    if (spur >= 0) begin
      bus.w_res_vld[spur] = 1'b1;
      err_exp = 1'b1;
      spur = -1;
    end
    dv = pend.size() > 0;
    if (dv) begin
      da = pend[0].a;
      db = pend[0].b;
      dc = pend[0].c;
    end else begin
      da = rnd();
      db = rnd();
      dc = rnd();
    end
    bus.arg_vld = dv;
    bus.a = da;
    bus.b = db;
    bus.c = dc;
    #1;
    exp_rdy = (na - ne) < N;
    n_checks++;
    if (bus.arg_rdy !== exp_rdy) begin
      n_fail++;
      $display("FAIL arg_rdy cyc %0d: got %b want %b",
               cyc, bus.arg_rdy, exp_rdy);
    end
    exp_sel = '0;
    if (dv && exp_rdy) exp_sel[na % N] = 1'b1;
    n_checks++;
    if (bus.w_arg_vld !== exp_sel) begin
      n_fail++;
      $display("FAIL w_arg_vld cyc %0d: got %b want %b",
               cyc, bus.w_arg_vld, exp_sel);
    end
    n_checks++;
    if ({bus.w_a, bus.w_b, bus.w_c} !== {da, db, dc}) begin
      n_fail++;
      $display("FAIL w_abc cyc %0d: got %0h %0h %0h want %0h %0h %0h",
               cyc, bus.w_a, bus.w_b, bus.w_c, da, db, dc);
    end
    if (dv && exp_rdy) begin
      w = na % N;
      w_act[w] = 1'b1;
      w_cnt[w] = lat[w];
      w_job[w] = na;
      w_val[w] = formula(da, db, dc);
      exp_val[na] = w_val[w];
      stb_cyc[na] = -1;
      na++;
      void'(pend.pop_front());
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic drain(input int budget, input string tag);
    int k = 0;
    while ((pend.size() > 0 || ne < na) && k < budget) begin
      tick();
      k++;
    end
    n_checks++;
    if (pend.size() > 0 || ne < na) begin
      n_fail++;
      $display("FAIL %s drain: got %0d of %0d emitted",
               tag, ne, na);
    end
    repeat (3) tick();
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if ({bus.res_vld, bus.err, bus.arg_rdy} !== 3'b001) begin
      n_fail++;
      $display("FAIL reset_flags: got %b want 001",
               {bus.res_vld, bus.err, bus.arg_rdy});
    end
    n_checks++;
    if (bus.res !== '0 || bus.w_arg_vld !== '0) begin
      n_fail++;
      $display("FAIL reset_data: got %0h/%b want 0/0",
               bus.res, bus.w_arg_vld);
    end
  endtask

  task automatic test_single();
    do_reset();
    set_lat(3, 3, 3, 3);
    push(6, 5, 16);
    drain(50, "single");
    n_checks++;
    if (bus.res !== 32'd3) begin
      n_fail++;
      $display("FAIL single_res: got %0d want 3", bus.res);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    set_lat(8, 8, 8, 8);
    push(0, 0, 0);
    push(0, 0, 1);
    push(0, 0, 4);
    push(0, 0, 9);
    drain(60, "b2b");
    n_checks++;
    if (bus.res !== 32'd1) begin
      n_fail++;
      $display("FAIL b2b_last: got %0d want 1", bus.res);
    end
  endtask

  task automatic test_out_of_order();
    do_reset();
    set_lat(20, 5, 5, 5);
    repeat (4) push(rnd(), rnd(), rnd());
    drain(80, "ooo");
  endtask

  task automatic test_backpressure();
    do_reset();
    set_lat(10, 10, 10, 10);
    repeat (6) push(rnd(), rnd(), rnd());
    drain(100, "bp");
  endtask

  task automatic test_spurious();
    do_reset();
    set_lat(4, 4, 4, 4);
    spur = 2;
    repeat (4) tick();
    push(rnd(), rnd(), rnd());
    drain(40, "spur");
    n_checks++;
    if (bus.err !== 1'b1) begin
      n_fail++;
      $display("FAIL err_sticky: got %b want 1", bus.err);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    set_lat(2, 30, 30, 30);
    push(rnd(), rnd(), rnd());
    drain(30, "pre");
    spur = 0;
    set_lat(30, 30, 30, 30);
    repeat (3) push(rnd(), rnd(), rnd());
    repeat (5) tick();
    rst = 1'b1;
    bus.arg_vld = 1'b0;
    bus.w_res_vld = '0;
    @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({bus.res_vld, bus.err, bus.arg_rdy} !== 3'b001) begin
      n_fail++;
      $display("FAIL mid_flags: got %b want 001",
               {bus.res_vld, bus.err, bus.arg_rdy});
    end
    n_checks++;
    if (bus.res !== '0 || bus.w_arg_vld !== '0) begin
      n_fail++;
      $display("FAIL mid_data: got %0h/%b want 0/0",
               bus.res, bus.w_arg_vld);
    end
    clear_model();
    rst = 1'b0;
    set_lat(6, 6, 6, 6);
    push(0, 0, 100);
    drain(40, "post");
    n_checks++;
    if (bus.res !== 32'd1) begin
      n_fail++;
      $display("FAIL mid_res: got %0d want 1", bus.res);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < N; i++) lat[i] = $urandom_range(1, 12);
    for (int j = 0; j < 40; j++) begin
      push(rnd(), rnd(), rnd());
      repeat ($urandom_range(0, 2)) tick();
    end
    drain(2000, "rand");
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    cyc = 0;
    rst = 1'b1;
    test_reset();
    test_single();
    test_back_to_back();
    test_out_of_order();
    test_backpressure();
    test_spurious();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/formula_2_distributor.md
Name: formula_2_distributor

Overview:
- Front-end stage that sits directly upstream of an array of N formula_2_fsm workers. Each worker computes isqrt(a + isqrt(b + isqrt(c))) with its own isqrt instance.
- Accepts one argument triple per cycle from upstream and dispatches it round-robin to a free worker.
- Collects worker results, which may arrive out of order, and re-emits them strictly in acceptance order.
- Raises throughput from one formula per ~3 isqrt latencies to up to N in flight.

Parameters:
- N_WORKERS, 4, number of attached formula workers; legal range 1..16, need not be a power of 2.
- W, 32, argument and result width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset: synchronous, active-high.
- arg_vld  in  1  upstream argument valid.
- a  in  W  argument a.
- b  in  W  argument b.
- c  in  W  argument c.
- arg_rdy  out  1  combinational; high when the worker at wr_ptr is free.
- res_vld  out  1  registered result strobe, one cycle wide.
- res  out  W  registered result, valid when res_vld=1.
- w_arg_vld  out  N_WORKERS  one-hot dispatch strobe, combinational.
- w_a  out  W  broadcast copy of a, pass-through.
- w_b  out  W  broadcast copy of b, pass-through.
- w_c  out  W  broadcast copy of c, pass-through.
- w_res_vld  in  N_WORKERS  per-worker result strobe.
- w_res  in  N_WORKERS*W  per-worker results; worker i occupies bits [i*W +: W].
- err  out  1  sticky protocol error flag.

Behaviour:
- State:
  - wr_ptr, rd_ptr: counters over 0..N_WORKERS-1; wrap from N_WORKERS-1 to 0.
  - busy[i]: worker i holds an accepted argument whose result has not yet been emitted.
  - done[i]: result of worker i is buffered in slot[i] (W bits).
- Reset: wr_ptr, rd_ptr, busy, done, res_vld, err all go to 0; res goes to 0. A reset mid-operation discards all in-flight work. Workers share rst, so no stale results can arrive afterwards.
- Dispatch:
  - arg_rdy = !busy[wr_ptr].
  - Accept occurs when arg_vld && arg_rdy.
  - On accept, in the same cycle: w_arg_vld[wr_ptr]=1. At the edge: busy[wr_ptr] <= 1 and wr_ptr advances.
  - w_a/w_b/w_c always equal a/b/c. w_arg_vld is all-zero when there is no accept.
  - arg_vld while arg_rdy=0: nothing is dispatched. Upstream must hold the argument.
- Collection:
  - When w_res_vld[i]=1 and busy[i]=1: slot[i] <= w_res[i], done[i] <= 1. Any number of workers may complete in the same cycle.
  - When w_res_vld[i]=1 and busy[i]=0: the result is ignored and err <= 1.
- Emission, at most one result per cycle, in order:
  - Fast path: if w_res_vld[rd_ptr] && busy[rd_ptr], then res <= w_res[rd_ptr] and res_vld <= 1. This bypass gives one cycle of latency from the worker strobe. done[rd_ptr] is not set.
  - Buffered path: else if done[rd_ptr], then res <= slot[rd_ptr] and res_vld <= 1.
  - Otherwise res_vld <= 0; res holds its previous value.
  - On emission: busy[rd_ptr] <= 0, done[rd_ptr] <= 0, and rd_ptr advances.
- Simultaneous events:
  - Emission from worker k and a new accept targeting the same worker k in the same cycle: the accept is blocked because arg_rdy reflects pre-edge busy. The freed worker becomes available the next cycle.
  - Dispatch and emission in the same cycle on different workers are independent.
- Ordering: results leave in exact acceptance order regardless of worker completion order. When all workers are busy, arg_rdy stays low until rd_ptr's result is emitted.
- Latency: res_vld is asserted 1 cycle after w_res_vld of the oldest worker. Buffered younger results drain one per cycle afterwards.

Decomposition:
- Package formula_dist_pkg holds:
  - the default N_WORKERS and W;
  - the ptr_t width function $clog2(N_WORKERS) with a minimum of 1;
  - the next_ptr wrap helper function.
- No sub-module inside the block; per-worker slot logic is generate-loop scale.
- The testbench top instantiates formula_2_distributor, N formula_2_fsm and N isqrt instances.

Test Plan:
- Single transaction: a=6, b=5, c=16 → res=3 exactly once. Intermediate values: isqrt(16)=4, isqrt(9)=3, isqrt(9)=3. Result arrives 1 cycle after the worker strobe; err=0.
- Back-to-back burst: 4 triples on consecutive cycles, c=0,1,4,9 with a=b=0 → res=0,1,1,1 in order. Triples go to workers 0..3. Expected values per formula: c=1 gives isqrt(0+isqrt(0+1))=1; c=4 gives isqrt(isqrt(2))=1; c=9 gives isqrt(isqrt(3))=1.
- Out-of-order completion: stub workers with latency 20/5/5/5. All 4 results are buffered, then emitted on 4 consecutive cycles in order 0,1,2,3.
- Backpressure: 6 triples with arg_vld held high and worker latency 10 → arg_rdy low after the 4th accept. The 5th accept occurs the cycle after the first emission. No drop and no duplicate.
- Spurious strobe: pulse w_res_vld[2] while busy[2]=0 → err=1 and stays set; res_vld is not asserted.
- Reset mid-operation: assert rst with 3 workers in flight → all outputs 0 next cycle. A new triple a=0, b=0, c=100 then gives res=isqrt(isqrt(10))=1, dispatched to worker 0.
